// File: rtl/double_adder_arbiter_pkg.sv
// Shared constants for the double_adder arbiter: operand width and
// controller state encoding.
package double_adder_arbiter_pkg;

  localparam int unsigned OpWidth = 64;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccept = 3'd1,
    StSendA  = 3'd2,
    StSendB  = 3'd3,
    StWaitZ  = 3'd4,
    StReturn = 3'd5
  } state_e;

endpackage

// File: rtl/double_adder_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module double_adder_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GW      = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic               valid,
  output logic [GW-1:0]      idx
);

  localparam int unsigned Slots = 2 ** GW;

  logic [Slots-1:0] req_ext;
  logic [GW:0]      sum;

  assign req_ext = Slots'(req);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      sum = {1'b0, ptr} + (GW + 1)'(off - 1);
      if (sum >= (GW + 1)'(NUM_REQ)) begin
        sum = sum - (GW + 1)'(NUM_REQ);
      end
      if (req_ext[sum[GW-1:0]]) begin
        valid = 1'b1;
        idx   = sum[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/double_adder_arbiter.sv
// Shares one double_adder between NUM_REQ requesters, one operation at a
// time, with round-robin grant order.
module double_adder_arbiter
  import double_adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GW      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OpWidth*NUM_REQ-1:0] req_a,
  input  logic [OpWidth*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_stb,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [OpWidth-1:0]         rsp_z,
  output logic [NUM_REQ-1:0]         rsp_stb,
  input  logic [NUM_REQ-1:0]         rsp_ack,
  output logic [OpWidth-1:0]         adder_a,
  output logic                       adder_a_stb,
  input  logic                       adder_a_ack,
  output logic [OpWidth-1:0]         adder_b,
  output logic                       adder_b_stb,
  input  logic                       adder_b_ack,
  input  logic [OpWidth-1:0]         adder_z,
  input  logic                       adder_z_stb,
  output logic                       adder_z_ack,
  output logic                       busy,
  output logic [GW-1:0]              grant
);

  localparam int unsigned Slots = 2 ** GW;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [OpWidth-1:0]   a_q, a_d, b_q, b_d;
  logic [OpWidth-1:0]   rsp_z_q, rsp_z_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]   rsp_stb_q, rsp_stb_d;
  logic                 a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;

  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_oh, grant_oh;
  logic [OpWidth-1:0]   op_a [Slots];
  logic [OpWidth-1:0]   op_b [Slots];

  // Padded to a power of two so a GW-bit grant indexes it without truncation.
  for (genvar i = 0; i < Slots; i++) begin : g_slot
    if (i < NUM_REQ) begin : g_used
      assign op_a[i] = req_a[i*OpWidth +: OpWidth];
      assign op_b[i] = req_b[i*OpWidth +: OpWidth];
    end else begin : g_pad
      assign op_a[i] = '0;
      assign op_b[i] = '0;
    end
  end

  double_adder_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req   (req_stb),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_oh[i]  = (pick_idx == GW'(i));
      grant_oh[i] = (grant_q == GW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_z_d   = rsp_z_q;
    req_ack_d = req_ack_q;
    rsp_stb_d = rsp_stb_q;
    a_stb_d   = a_stb_q;
    b_stb_d   = b_stb_q;
    z_ack_d   = z_ack_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          req_ack_d = pick_oh;
          state_d   = StAccept;
        end
      end
      StAccept: begin
        // Only the granted bit of req_ack is ever set, so the AND isolates it.
        if (|(req_stb & req_ack_q)) begin
          a_d       = op_a[grant_q];
          b_d       = op_b[grant_q];
          req_ack_d = '0;
          a_stb_d   = 1'b1;
          state_d   = StSendA;
        end
      end
      StSendA: begin
        if (a_stb_q && adder_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = StSendB;
        end
      end
      StSendB: begin
        if (b_stb_q && adder_b_ack) begin
          b_stb_d = 1'b0;
          z_ack_d = 1'b1;
          state_d = StWaitZ;
        end
      end
      StWaitZ: begin
        if (adder_z_stb && z_ack_q) begin
          rsp_z_d   = adder_z;
          z_ack_d   = 1'b0;
          rsp_stb_d = grant_oh;
          state_d   = StReturn;
        end
      end
      StReturn: begin
        if (|(rsp_stb_q & rsp_ack)) begin
          rsp_stb_d = '0;
          ptr_d     = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_z_q   <= '0;
      req_ack_q <= '0;
      rsp_stb_q <= '0;
      a_stb_q   <= 1'b0;
      b_stb_q   <= 1'b0;
      z_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rsp_z_q   <= rsp_z_d;
      req_ack_q <= req_ack_d;
      rsp_stb_q <= rsp_stb_d;
      a_stb_q   <= a_stb_d;
      b_stb_q   <= b_stb_d;
      z_ack_q   <= z_ack_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign rsp_z       = rsp_z_q;
  assign rsp_stb     = rsp_stb_q;
  assign adder_a     = a_q;
  assign adder_a_stb = a_stb_q;
  assign adder_b     = b_q;
  assign adder_b_stb = b_stb_q;
  assign adder_z_ack = z_ack_q;
  assign busy        = (state_q != StIdle);
  assign grant       = grant_q;

endmodule
